// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
//
// Shared raster constants for the 640x480@60 video path. Renderers import this
// package for their own area compares, so the numbers here are the single
// source of truth for the visible window and the porch/sync layout.
//
// Contents:
//   H_* / V_*   : horizontal (pixels) and vertical (lines) timing segments
//   H_TOTAL     : pixels per line  (800)
//   V_TOTAL     : lines per frame  (525)
//   COORD_W     : width of the coordinate / tick buses handed to renderers
//   CNT_W       : width actually needed to hold a coordinate (upper bits of
//                 the COORD_W buses are always zero)
//   sync_t      : {hs_n, vs_n, de} bundle carried through the delay line
//   SYNC_IDLE   : inactive value of sync_t (syncs high, display disabled)
//   in_span()   : inclusive range test used by the sync decoders
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int COORD_W = 25;
    localparam int CNT_W   = 10;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};

    // Inclusive range test: lo <= v <= hi.
    function automatic logic in_span(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_sync_delay_line
//
// Enable-gated shift register for the {hs_n, vs_n, de} bundle. It lines the
// sync/enable outputs up with the registered colour outputs of the renderers,
// which advance only on pixel-enable cycles.
//
// Parameters:
//   DEPTH : number of register stages; 0 gives a combinational passthrough
//   FILL  : value loaded into every stage on reset
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (stages load FILL)
//   en     in   shift enable (pixel clock enable)
//   d      in   undelayed bundle
//   q      out  bundle delayed by DEPTH enabled steps
// -----------------------------------------------------------------------------
module vga_timing_gen_sync_delay_line
    import vga_timing_gen_pkg::*;
#(
    parameter int    DEPTH = 1,
    parameter sync_t FILL  = SYNC_IDLE
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  sync_t d,
    output sync_t q
);

    generate
        if (DEPTH == 0) begin : g_passthru
            // Clock/reset/enable have no function without stages.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign q = d;
        end else begin : g_stages
            sync_t stage_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= FILL;
                    end
                end else if (en) begin
                    stage_q[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the 640x480@60 video path. Produces the pixel
// coordinates and a free-running tick bus for the renderers, plus sync and
// display-enable delayed to match the renderers' registered colour outputs.
//
// Optional feature (compile-time macro VGA_TIMING_FRAME_PULSE_EN):
//   defined   : frame_start pulses for one clk on the pixel-enable cycle in
//               which both counters wrap to 0
//   undefined : frame_start is tied low, no detection logic
//
// Parameters:
//   H_VIS/H_FP/H_SYNC/H_BP : horizontal segments in pixels
//   V_VIS/V_FP/V_SYNC/V_BP : vertical segments in lines
//   CLK_DIV                : clk cycles per pixel (1..4)
//   PIPE_DLY               : pixel-enable steps of delay on sync/enable (0..4)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   Clks         out  free-running tick counter, +1 every clk
//   CounterX     out  pixel column 0..H_TOTAL-1
//   CounterY     out  line 0..V_TOTAL-1
//   pix_ce       out  high in the clk cycle whose closing edge advances X/Y
//   hsync_n      out  horizontal sync, active low, delayed PIPE_DLY steps
//   vsync_n      out  vertical sync, active low, delayed PIPE_DLY steps
//   display_en   out  visible-area flag, delayed PIPE_DLY steps
//   frame_start  out  frame-origin pulse (see optional feature)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VIS    = vga_timing_gen_pkg::H_VIS,
    parameter int H_FP     = vga_timing_gen_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_gen_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_gen_pkg::H_BP,
    parameter int V_VIS    = vga_timing_gen_pkg::V_VIS,
    parameter int V_FP     = vga_timing_gen_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_gen_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_gen_pkg::V_BP,
    parameter int CLK_DIV  = 1,
    parameter int PIPE_DLY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] Clks,
    output logic [COORD_W-1:0] CounterX,
    output logic [COORD_W-1:0] CounterY,
    output logic               pix_ce,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               display_en,
    output logic               frame_start
);

    localparam int LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(FRAME_LINES - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [1:0]       DIV_LAST = 2'(CLK_DIV - 1);

    // Elaboration-time range guards.
    if ((CLK_DIV < 1) || (CLK_DIV > 4)) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be in 1..4");
    end
    if ((PIPE_DLY < 0) || (PIPE_DLY > 4)) begin : g_bad_pipe_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..4");
    end

    logic [COORD_W-1:0] clks_q;
    logic [1:0]         div_q;
    logic [1:0]         div_d;
    logic               pix_ce_q;
    logic [CNT_W-1:0]   x_q;
    logic [CNT_W-1:0]   y_q;
    logic               x_last;
    logic               y_last;
    sync_t              raw;
    sync_t              dly;

    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);

    always_comb begin
        div_d = div_q + 2'd1;
        if (div_q == DIV_LAST) begin
            div_d = 2'd0;
        end
    end

    // pix_ce is registered from the divider's next value, so it is high
    // exactly while div_q == CLK_DIV-1; with CLK_DIV=1 it rises on the first
    // edge after reset and stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clks_q   <= '0;
            div_q    <= 2'd0;
            pix_ce_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            clks_q   <= clks_q + COORD_W'(1);
            div_q    <= div_d;
            pix_ce_q <= (div_d == DIV_LAST);
            if (pix_ce_q) begin
                if (x_last) begin
                    x_q <= '0;
                    if (y_last) begin
                        y_q <= '0;
                    end else begin
                        y_q <= y_q + CNT_W'(1);
                    end
                end else begin
                    x_q <= x_q + CNT_W'(1);
                end
            end
        end
    end

    // Undelayed decode of the current coordinates.
    always_comb begin
        raw      = SYNC_IDLE;
        raw.hs_n = !in_span(x_q, HS_FIRST, HS_LAST);
        raw.vs_n = !in_span(y_q, VS_FIRST, VS_LAST);
        raw.de   = (x_q < X_VIS) && (y_q < Y_VIS);
    end

    vga_timing_gen_sync_delay_line #(
        .DEPTH (PIPE_DLY),
        .FILL  (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce_q),
        .d     (raw),
        .q     (dly)
    );

`ifdef VGA_TIMING_FRAME_PULSE_EN
    // High during the pixel-enable cycle whose closing edge wraps X and Y.
    assign frame_start = pix_ce_q & x_last & y_last;
`else
    assign frame_start = 1'b0;
`endif

    assign Clks       = clks_q;
    assign CounterX   = COORD_W'(x_q);
    assign CounterY   = COORD_W'(y_q);
    assign pix_ce     = pix_ce_q;
    assign hsync_n    = dly.hs_n;
    assign vsync_n    = dly.vs_n;
    assign display_en = dly.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Five instances share one clock/reset:
//   D  : default 640x480 timing, CLK_DIV=1, PIPE_DLY=1
//   P0 : default timing, PIPE_DLY=0
//   P3 : default timing, PIPE_DLY=3
//   S  : miniature raster 16x8 (H 8/2/3/3, V 4/1/2/1), CLK_DIV=1, PIPE_DLY=1
//   S2 : same miniature raster with CLK_DIV=2
// The miniature rasters exercise vertical sync, frame wrap and frame_start
// in a few hundred cycles. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int D  = 0;
    localparam int P0 = 1;
    localparam int P3 = 2;
    localparam int S  = 3;
    localparam int S2 = 4;

`ifdef VGA_TIMING_FRAME_PULSE_EN
    localparam int EXP_S_PULSES  = 2;
    localparam int EXP_S2_PULSES = 1;
`else
    localparam int EXP_S_PULSES  = 0;
    localparam int EXP_S2_PULSES = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] clks [5];
    logic [24:0] cx   [5];
    logic [24:0] cy   [5];
    logic        pce  [5];
    logic        hs   [5];
    logic        vs   [5];
    logic        de   [5];
    logic        fs   [5];

    vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(1)) u_d (
        .clk(clk), .rst_n(rst_n), .Clks(clks[D]), .CounterX(cx[D]), .CounterY(cy[D]),
        .pix_ce(pce[D]), .hsync_n(hs[D]), .vsync_n(vs[D]), .display_en(de[D]),
        .frame_start(fs[D]));

    vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0)) u_p0 (
        .clk(clk), .rst_n(rst_n), .Clks(clks[P0]), .CounterX(cx[P0]), .CounterY(cy[P0]),
        .pix_ce(pce[P0]), .hsync_n(hs[P0]), .vsync_n(vs[P0]), .display_en(de[P0]),
        .frame_start(fs[P0]));

    vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .Clks(clks[P3]), .CounterX(cx[P3]), .CounterY(cy[P3]),
        .pix_ce(pce[P3]), .hsync_n(hs[P3]), .vsync_n(vs[P3]), .display_en(de[P3]),
        .frame_start(fs[P3]));

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .PIPE_DLY(1)
    ) u_s (
        .clk(clk), .rst_n(rst_n), .Clks(clks[S]), .CounterX(cx[S]), .CounterY(cy[S]),
        .pix_ce(pce[S]), .hsync_n(hs[S]), .vsync_n(vs[S]), .display_en(de[S]),
        .frame_start(fs[S]));

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .PIPE_DLY(1)
    ) u_s2 (
        .clk(clk), .rst_n(rst_n), .Clks(clks[S2]), .CounterX(cx[S2]), .CounterY(cy[S2]),
        .pix_ce(pce[S2]), .hsync_n(hs[S2]), .vsync_n(vs[S2]), .display_en(de[S2]),
        .frame_start(fs[S2]));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string pfx, input int k);
        check({pfx, "_clks"},  int'(clks[k]), 0);
        check({pfx, "_x"},     int'(cx[k]),   0);
        check({pfx, "_y"},     int'(cy[k]),   0);
        check({pfx, "_pix_ce"}, int'(pce[k]), 0);
        check({pfx, "_hsync"}, int'(hs[k]),   1);
        check({pfx, "_vsync"}, int'(vs[k]),   1);
        check({pfx, "_de"},    int'(de[k]),   0);
        check({pfx, "_fs"},    int'(fs[k]),   0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hs_fall_d, hs_fall_p3, hs_low_d, vs_low_d;
        int de_fall_d, de_fall_p0, de_fall_p3;
        int vs_low_s, vs_fall_xy, s_pulses, s2_pulses, s2_ce;
        int s_wrap_i, s2_wrap_i, prev_y_s, prev_y_s2;

        rst_n = 1'b0;
        step(3);
        check_reset_vals("rst", D);
        check_reset_vals("rst_s2", S2);

        // Release between edges; counting starts at the next rising edge.
        rst_n = 1'b1;
        step(1);
        check("ce_first",    int'(pce[D]),  1);
        check("x_first",     int'(cx[D]),   0);
        check("clks_first",  int'(clks[D]), 1);
        check("de_unshifted", int'(de[D]),  0);
        check("s2_ce_first", int'(pce[S2]), 1);
        check("s2_x_first",  int'(cx[S2]),  0);

        step(1);
        check("x_second",    int'(cx[D]),   1);
        check("de_shifted",  int'(de[D]),   1);
        check("hs_idle",     int'(hs[D]),   1);
        check("clks_second", int'(clks[D]), 2);
        check("s2_ce_off",   int'(pce[S2]), 0);
        check("s2_x_second", int'(cx[S2]),  1);

        step(3);
        check("x_fifth", int'(cx[D]), 4);

        // One full line plus a bit, watching sync/enable edges.
        hs_fall_d = -1; hs_fall_p3 = -1; hs_low_d = 0; vs_low_d = 0;
        de_fall_d = -1; de_fall_p0 = -1; de_fall_p3 = -1;
        for (int i = 0; i < 900; i++) begin
            step(1);
            if (!hs[D]) hs_low_d++;
            if (!vs[D]) vs_low_d++;
            if (!hs[D]  && hs_fall_d  < 0) hs_fall_d  = int'(cx[D]);
            if (!hs[P3] && hs_fall_p3 < 0) hs_fall_p3 = int'(cx[P3]);
            if (!de[D]  && de_fall_d  < 0) de_fall_d  = int'(cx[D]);
            if (!de[P0] && de_fall_p0 < 0) de_fall_p0 = int'(cx[P0]);
            if (!de[P3] && de_fall_p3 < 0) de_fall_p3 = int'(cx[P3]);
            if (cx[D] == 25'd0) check("y_step_on_x_wrap", int'(cy[D]), 1);
        end
        check("hs_fall_x",     hs_fall_d,  657);
        check("hs_low_len",    hs_low_d,   96);
        check("hs_fall_x_p3",  hs_fall_p3, 659);
        check("vs_idle_line",  vs_low_d,   0);
        check("de_fall_x",     de_fall_d,  641);
        check("de_fall_x_p0",  de_fall_p0, 640);
        check("de_fall_x_p3",  de_fall_p3, 643);
        check("line_end_x",    int'(cx[D]),   104);
        check("line_end_y",    int'(cy[D]),   1);
        check("line_end_clks", int'(clks[D]), 905);

        // Asynchronous reset in the middle of a line.
        for (int k = 0; k < 1000 && cx[D] != 25'd700; k++) step(1);
        check("reach_x700", int'(cx[D]), 700);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async", D);
        check_reset_vals("async_p3", P3);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("resume_x",    int'(cx[D]),   0);
        check("resume_y",    int'(cy[D]),   0);
        check("resume_ce",   int'(pce[D]),  1);
        check("resume_clks", int'(clks[D]), 1);

        // Miniature rasters: vertical sync, frame wrap, frame_start, CLK_DIV=2.
        vs_low_s = 0; vs_fall_xy = -1; s_pulses = 0; s2_pulses = 0; s2_ce = 0;
        s_wrap_i = -1; s2_wrap_i = -1;
        prev_y_s = int'(cy[S]); prev_y_s2 = int'(cy[S2]);
        for (int i = 2; i <= 301; i++) begin
            step(1);
            if (!vs[S]) vs_low_s++;
            if (!vs[S] && vs_fall_xy < 0) vs_fall_xy = int'(cx[S]) * 100 + int'(cy[S]);
            if (pce[S2]) s2_ce++;
            if (fs[S]) begin
                s_pulses++;
                check("fs_loc_s", int'(cx[S]) * 100 + int'(cy[S]), 1507);
            end
            if (fs[S2]) begin
                s2_pulses++;
                check("fs_loc_s2", int'(cx[S2]) * 100 + int'(cy[S2]), 1507);
            end
            if (prev_y_s == 7 && cy[S] == 25'd0) begin
                check("s_wrap_x", int'(cx[S]), 0);
                if (s_wrap_i < 0) s_wrap_i = i;
            end
            if (prev_y_s2 == 7 && cy[S2] == 25'd0 && s2_wrap_i < 0) s2_wrap_i = i;
            prev_y_s  = int'(cy[S]);
            prev_y_s2 = int'(cy[S2]);
        end
        check("s_vs_low_len",  vs_low_s,   64);
        check("s_vs_fall_xy",  vs_fall_xy, 105);
        check("s_wrap_clk",    s_wrap_i,   129);
        check("s2_wrap_clk",   s2_wrap_i,  256);
        check("s2_ce_count",   s2_ce,      150);
        check("s_fs_pulses",   s_pulses,   EXP_S_PULSES);
        check("s2_fs_pulses",  s2_pulses,  EXP_S2_PULSES);
        check("s_end_x",       int'(cx[S]),    12);
        check("s_end_y",       int'(cy[S]),    2);
        check("s2_end_x",      int'(cx[S2]),   6);
        check("s2_end_y",      int'(cy[S2]),   1);
        check("s2_end_clks",   int'(clks[S2]), 301);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
